// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Boot-time controller that fills the instruction memory of the single-cycle
//   core from a byte-serial load stream, holding the core in reset while it
//   loads and releasing it once the whole image has been written.
//
//   Stream: 4-byte big-endian length N, then N big-endian 32-bit data words.
//
// Ports
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   start         one-cycle pulse, begins a session from IDLE/DONE/ERR
//   in_valid      load byte valid
//   in_data       load byte
//   in_ready      loader accepts a byte (transfer on in_valid && in_ready)
//   mem_we        instruction memory write enable, one pulse per word
//   mem_addr      word address of the write
//   mem_wdata     word to write
//   cpu_reset_n   active-low reset to the core, high only in DONE
//   busy          session in progress (LEN or LOAD)
//   done          last session completed successfully
//   error         last session aborted (length too large)
//   words_loaded  words written in the current or last session
module imem_boot_loader #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             mem_we,
  output logic [DEPTH-1:0] mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             cpu_reset_n,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [DEPTH:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_LOAD,
    S_DONE,
    S_ERR
  } state_t;

  // Largest legal length; 33 bits so the compare cannot overflow.
  localparam logic [32:0] CAP = 33'(1) << DEPTH;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_byte_cnt;
  logic [23:0]      r_shift;
  logic [DEPTH:0]   r_len;

  logic             w_fire;
  logic             w_word_done;
  logic [31:0]      w_word;
  logic [DEPTH:0]   w_words_inc;
  logic             w_last_write;
  logic             w_sess_start;
  logic             w_len_zero;
  logic             w_len_big;

  logic             w_in_ready_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_error_nxt;
  logic             w_cpu_rstn_nxt;

  assign w_fire       = in_valid & in_ready;
  assign w_word_done  = w_fire & (r_byte_cnt == 2'd3);
  // First three bytes sit in r_shift; the current byte completes the word.
  assign w_word       = {r_shift, in_data};
  assign w_words_inc  = words_loaded + 1'b1;
  assign w_last_write = (w_words_inc == r_len);
  assign w_len_zero   = (w_word == 32'd0);
  assign w_len_big    = ({1'b0, w_word} > CAP);
  assign w_sess_start = start &
                        ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERR));

  // State register plus status outputs, registered from the next state so
  // each status output lines up with the state it describes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      cpu_reset_n <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      in_ready    <= w_in_ready_nxt;
      busy        <= w_busy_nxt;
      done        <= w_done_nxt;
      error       <= w_error_nxt;
      cpu_reset_n <= w_cpu_rstn_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) w_state_nxt = S_LEN;
      end
      S_LEN: begin
        if (w_word_done) begin
          if (w_len_zero)     w_state_nxt = S_DONE;
          else if (w_len_big) w_state_nxt = S_ERR;
          else                w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_word_done && w_last_write) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode on the next state.
  always_comb begin
    w_in_ready_nxt = 1'b0;
    w_busy_nxt     = 1'b0;
    w_done_nxt     = 1'b0;
    w_error_nxt    = 1'b0;
    w_cpu_rstn_nxt = 1'b0;
    case (w_state_nxt)
      S_LEN, S_LOAD: begin
        w_in_ready_nxt = 1'b1;
        w_busy_nxt     = 1'b1;
      end
      S_DONE: begin
        w_done_nxt     = 1'b1;
        w_cpu_rstn_nxt = 1'b1;
      end
      S_ERR: begin
        w_error_nxt    = 1'b1;
      end
      default: ;
    endcase
  end

  // Byte assembly, length latch and memory write port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_byte_cnt   <= '0;
      r_shift      <= '0;
      r_len        <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      words_loaded <= '0;
    end else begin
      mem_we <= 1'b0;
      if (w_sess_start) begin
        r_byte_cnt   <= '0;
        words_loaded <= '0;
      end else if (w_fire) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        r_shift    <= {r_shift[15:0], in_data};
        if (w_word_done) begin
          if (r_state == S_LEN) begin
            // Only consumed when the length is legal, so DEPTH+1 bits suffice.
            r_len <= w_word[DEPTH:0];
          end else if (r_state == S_LOAD) begin
            mem_we       <= 1'b1;
            mem_addr     <= words_loaded[DEPTH-1:0];
            mem_wdata    <= w_word;
            words_loaded <= w_words_inc;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader (DEPTH = 8): randomized byte streams checked
// against a session-level model of the expected writes and final status.
module tb_imem_boot_loader;

  localparam int          DEPTH = 8;
  localparam int unsigned CAP   = 256;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = '0;
  logic             in_ready;
  logic             mem_we;
  logic [DEPTH-1:0] mem_addr;
  logic [31:0]      mem_wdata;
  logic             cpu_reset_n;
  logic             busy;
  logic             done;
  logic             error;
  logic [DEPTH:0]   words_loaded;

  imem_boot_loader #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_reset_n  (cpu_reset_n),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int unsigned      cyc;
    logic [DEPTH-1:0] addr;
    logic [31:0]      data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] shadow [CAP];
  logic [31:0] words  [CAP];
  int unsigned n_writes = 0;

  // Write monitor: every observed write must match the next expected one,
  // including the cycle it appears in.
  always begin
    @(negedge clk);
    #1;
    if (reset_n && mem_we) begin
      n_writes++;
      shadow[mem_addr] = mem_wdata;
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        check_val("wr_addr", mem_addr, e.addr);
        check_val("wr_data", mem_wdata, e.data);
        check_val("wr_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge after the accepting edge; acc = that edge's index.
  task automatic send_byte(input logic [7:0] b, output int unsigned acc);
    int  n;
    logic ok;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    do begin
      ok = in_ready;
      @(negedge clk);
      n++;
    end while (!ok && n < 50);
    in_valid = 1'b0;
    acc = cyc;
    if (!ok) check_val("accept_timeout", n, 0);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap, input bit rnd, output int unsigned acc);
    logic [31:0] v;
    v = w;
    for (int i = 3; i >= 0; i--) begin
      idle(rnd ? int'($urandom_range(gap, 0)) : gap);
      send_byte(v[i*8 +: 8], acc);
    end
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One full session; words[] holds the data words to send.
  task automatic run_session(input logic [31:0] n, input int gap, input bit rnd, input bit mid_start);
    int unsigned acc;
    int unsigned exp_words;
    int unsigned wr0;
    bit          ok_len;
    wr0 = n_writes;
    ok_len = (n != 0) && (n <= CAP);
    exp_words = ok_len ? n : 0;
    pulse_start;
    check_val("len_in_ready", in_ready, 1);
    check_val("len_busy", busy, 1);
    check_val("len_words", words_loaded, 0);
    check_val("len_cpu_rstn", cpu_reset_n, 0);
    check_val("len_done", done, 0);
    check_val("len_error", error, 0);
    send_word(n, gap, rnd, acc);
    if (ok_len) begin
      for (int unsigned i = 0; i < n; i++) begin
        if (mid_start && i == n / 2) begin
          pulse_start;
          check_val("mid_start_busy", busy, 1);
          check_val("mid_start_words", words_loaded, i);
          check_val("mid_start_ready", in_ready, 1);
        end
        check_val("load_cpu_rstn", cpu_reset_n, 0);
        send_word(words[i], gap, rnd, acc);
        exp_q.push_back('{acc, DEPTH'(i), words[i]});
      end
    end
    check_val("end_done", done, (n <= CAP) ? 1 : 0);
    check_val("end_error", error, (n > CAP) ? 1 : 0);
    check_val("end_cpu_rstn", cpu_reset_n, (n <= CAP) ? 1 : 0);
    check_val("end_busy", busy, 0);
    check_val("end_in_ready", in_ready, 0);
    check_val("end_words", words_loaded, exp_words);
    idle(2);
    check_val("pending_writes", exp_q.size(), 0);
    check_val("write_count", n_writes - wr0, exp_words);
    for (int unsigned i = 0; i < exp_words; i++)
      if (shadow[i] !== words[i]) check_val("mem_content", shadow[i], words[i]);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int unsigned acc;
    logic [31:0] n;

    // Reset state
    idle(2);
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_mem_we", mem_we, 0);
    check_val("rst_mem_addr", mem_addr, 0);
    check_val("rst_mem_wdata", mem_wdata, 0);
    check_val("rst_cpu_rstn", cpu_reset_n, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_error", error, 0);
    check_val("rst_words", words_loaded, 0);
    reset_n = 1'b1;
    idle(3);
    check_val("idle_in_ready", in_ready, 0);
    check_val("idle_cpu_rstn", cpu_reset_n, 0);

    // Normal load
    words[0] = 32'h2010000A;
    words[1] = 32'h20110014;
    run_session(2, 0, 0, 0);

    // Zero length
    run_session(0, 0, 0, 0);

    // Oversize length, then recovery
    run_session(257, 0, 0, 0);
    for (int i = 0; i < 3; i++) words[i] = $urandom;
    run_session(3, 2, 1, 0);

    // Stalled stream, then bytes offered while DONE must be ignored
    words[0] = 32'hAC120000;
    run_session(1, 3, 0, 0);
    in_valid = 1'b1;
    in_data  = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("done_in_ready", in_ready, 0);
      check_val("done_hold", done, 1);
      check_val("done_words", words_loaded, 1);
    end
    in_valid = 1'b0;

    // Reset mid-load: length 3, one full word plus two bytes, then reset
    for (int i = 0; i < 3; i++) words[i] = $urandom;
    pulse_start;
    send_word(3, 0, 0, acc);
    send_word(words[0], 0, 0, acc);
    exp_q.push_back('{acc, 8'd0, words[0]});
    n = words[1];
    send_byte(n[31:24], acc);
    send_byte(n[23:16], acc);
    reset_n = 1'b0;
    #1;
    check_val("mid_rst_in_ready", in_ready, 0);
    check_val("mid_rst_mem_we", mem_we, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_words", words_loaded, 0);
    check_val("mid_rst_cpu_rstn", cpu_reset_n, 0);
    check_val("mid_rst_done", done, 0);
    check_val("mid_rst_pending", exp_q.size(), 0);
    idle(2);
    reset_n = 1'b1;
    idle(1);
    words[0] = 32'h08000003;
    run_session(1, 0, 0, 0);

    // Reload from DONE with an ignored start during LOAD
    for (int i = 0; i < 6; i++) words[i] = $urandom;
    run_session(6, 1, 1, 1);

    // Full capacity
    for (int i = 0; i < int'(CAP); i++) words[i] = $urandom;
    run_session(CAP, 0, 0, 0);

    // Randomized sessions
    for (int s = 0; s < 10; s++) begin
      case ($urandom_range(9, 0))
        0:       n = 0;
        1:       n = CAP + 1 + $urandom_range(1000, 0);
        2:       n = $urandom | 32'h8000_0000;
        default: n = $urandom_range(20, 1);
      endcase
      for (int i = 0; i < 20; i++) words[i] = $urandom;
      run_session(n, 2, 1, bit'($urandom_range(1, 0)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
